// File: rtl/unary_add_sched_pkg.sv
// rtl/unary_add_sched_pkg.sv - shared defaults and FSM state encoding for unary_add_sched
//
// Purpose: holds the default operand/feed/result/window sizes and the
// scheduler state constants used by the top level.
// Ports: none (package).
package unary_add_sched_pkg;

  localparam int OPW_DEF     = 4;   // binary operand width
  localparam int LEN_DEF     = 15;  // unary feed length, 2^OPW-1
  localparam int RW_DEF      = 5;   // result width
  localparam int OUT_WIN_DEF = 32;  // emit-mode observation window

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_CLR   = 3'd1;
  localparam state_t S_FEED  = 3'd2;
  localparam state_t S_DRAIN = 3'd3;
  localparam state_t S_RESP  = 3'd4;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter
//
// Purpose: picks one of two requesters; on contention the one not served
// last wins. After reset requester 0 is favoured.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   valid[1:0]   - requester has a job
//   advance      - the current grant was accepted this cycle
//   grant[1:0]   - one-hot grant (zero when nobody is valid)
//   gid          - index of the granted requester
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       gid
);

  // Index of the requester served most recently. Resetting to 1 makes
  // requester 0 the winner of the first contention.
  logic r_last;
  logic w_pick1;

  always_comb begin
    w_pick1 = 1'b0;
    if (valid == 2'b11) w_pick1 = ~r_last;
    else                w_pick1 = valid[1];
  end

  assign gid   = w_pick1;
  assign grant = (valid == 2'b00) ? 2'b00 : (w_pick1 ? 2'b10 : 2'b01);

  always_ff @(posedge clk) begin
    if (rst)          r_last <= 1'b1;
    else if (advance) r_last <= w_pick1;
  end

endmodule

// File: rtl/unary_add_sched.sv
// rtl/unary_add_sched.sv - schedules jobs from two requesters onto an external unary adder
//
// Purpose: accepts (a, b) jobs from two round-robin arbitrated requesters,
// clears the external unary adder, feeds both operands as thermometer-coded
// bitstreams, then counts the adder's serial output into a saturating sum
// that is returned with the requester id and an overflow flag.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   req0_*/req1_*             - job request handshakes and operands
//   rsp_valid/rsp_ready       - response handshake
//   rsp_id, rsp_sum, rsp_ovf  - source requester, A+B, saturation/carry seen
//   ua_A, ua_B, ua_en, ua_rw  - bitstreams, enable and mode to the adder
//   ua_rst_n                  - active-low clear to the adder
//   ua_dout, ua_C             - serial count output and carry from the adder
module unary_add_sched
  import unary_add_sched_pkg::*;
#(
  parameter int OPW     = OPW_DEF,
  parameter int LEN     = LEN_DEF,
  parameter int RW      = RW_DEF,
  parameter int OUT_WIN = OUT_WIN_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  input  logic           req1_valid,
  output logic           req0_ready,
  output logic           req1_ready,
  input  logic [OPW-1:0] req0_a,
  input  logic [OPW-1:0] req0_b,
  input  logic [OPW-1:0] req1_a,
  input  logic [OPW-1:0] req1_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [RW-1:0]  rsp_sum,
  output logic           rsp_ovf,
  output logic           ua_A,
  output logic           ua_B,
  output logic           ua_en,
  output logic           ua_rw,
  output logic           ua_rst_n,
  input  logic           ua_dout,
  input  logic           ua_C
);

  // One phase counter serves both FEED and DRAIN, so it is sized for the longer.
  localparam int CW = $clog2(((LEN > OUT_WIN) ? LEN : OUT_WIN) + 1);
  localparam logic [CW-1:0] FEED_LAST  = CW'(LEN - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(OUT_WIN - 1);

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [OPW-1:0] r_a;
  logic [OPW-1:0] r_b;
  logic           r_id;
  logic [RW-1:0]  r_sum;
  logic           r_ovf;

  logic [1:0] w_grant;
  logic       w_gid;
  logic       w_idle;
  logic       w_accept;
  logic       w_feed;
  logic       w_drain;

  // Ready is a pure function of state and grant, and is held low while rst
  // is asserted so no job can be accepted in a reset cycle.
  assign w_idle     = (r_state == S_IDLE) && !rst;
  assign req0_ready = w_idle && w_grant[0];
  assign req1_ready = w_idle && w_grant[1];
  assign w_accept   = req0_ready || req1_ready;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   ({req1_valid, req0_valid}),
    .advance (w_accept),
    .grant   (w_grant),
    .gid     (w_gid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_id    <= 1'b0;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= w_gid ? req1_a : req0_a;
            r_b     <= w_gid ? req1_b : req0_b;
            r_id    <= w_gid;
            r_state <= S_CLR;
          end
        end
        S_CLR: begin
          r_sum   <= '0;
          r_ovf   <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_FEED;
        end
        S_FEED: begin
          if (r_cnt == FEED_LAST) begin
            r_cnt   <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (ua_C) r_ovf <= 1'b1;
          // A pulse that arrives with the counter already full is lost, so
          // it is reported as overflow instead.
          if (ua_dout) begin
            if (&r_sum) r_ovf <= 1'b1;
            else        r_sum <= r_sum + 1'b1;
          end
          if (r_cnt == DRAIN_LAST) begin
            r_cnt   <= '0;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_feed  = !rst && (r_state == S_FEED);
  assign w_drain = !rst && (r_state == S_DRAIN);

  // Thermometer code: operand x gives ones on phases 0..x-1 only.
  assign ua_A     = w_feed && (r_cnt < CW'(r_a));
  assign ua_B     = w_feed && (r_cnt < CW'(r_b));
  assign ua_en    = w_feed || w_drain;
  assign ua_rw    = w_drain;
  assign ua_rst_n = !rst && (r_state != S_CLR);

  assign rsp_valid = (r_state == S_RESP);
  assign rsp_id    = r_id;
  assign rsp_sum   = r_sum;
  assign rsp_ovf   = r_ovf;

endmodule
